// File: rtl/lsu.sv
// Load/store unit: single-outstanding req/gnt/rvalid data-memory master with lane alignment.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are dropped and flagged on misalign.
//
// state  | meaning
// IDLE   | ready for a new op from execute
// REQ    | dmem_req asserted, bus outputs frozen until dmem_gnt
// RESP   | load granted, waiting for dmem_rvalid
module lsu #(
  parameter int XLEN = 32,
  parameter int RDW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_we,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [RDW-1:0]  ex_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [RDW-1:0]  wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            st_done,
  output logic            misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t          state;
  logic [1:0]      off_q;
  logic [2:0]      funct3_q;
  logic [RDW-1:0]  rd_q;

  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] load_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic            go_c;

  assign ex_ready = (state == S_IDLE);

  // funct3[1:0]: 00 byte, 01 half, anything else (incl. illegal codes) word
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ex_addr[1:0];
        wdata_c = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = ex_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{ex_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = ex_wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_c;
  always_comb begin
    mis_c = 1'b0;
    case (ex_funct3[1:0])
      2'b00:   mis_c = 1'b0;
      2'b01:   mis_c = ex_addr[0];
      default: mis_c = |ex_addr[1:0];
    endcase
  end
  assign go_c = ex_valid & ~mis_c;
`else
  assign go_c = ex_valid;
`endif

  always_comb begin
    byte_c = 8'h00;
    case (off_q)
      2'd0: byte_c = dmem_rdata[7:0];
      2'd1: byte_c = dmem_rdata[15:8];
      2'd2: byte_c = dmem_rdata[23:16];
      2'd3: byte_c = dmem_rdata[31:24];
      default: byte_c = 8'h00;
    endcase
    half_c = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_c = funct3_q[2] ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   load_c = funct3_q[2] ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: load_c = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      st_done    <= 1'b0;
      misalign   <= 1'b0;
      off_q      <= 2'b00;
      funct3_q   <= 3'b000;
      rd_q       <= '0;
    end else begin
      wb_valid <= 1'b0;
      st_done  <= 1'b0;
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (ex_valid && mis_c) misalign <= 1'b1;
`endif
          if (go_c) begin
            state      <= S_REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= ex_we;
            dmem_be    <= be_c;
            dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
            dmem_wdata <= wdata_c;
            off_q      <= ex_addr[1:0];
            funct3_q   <= ex_funct3;
            rd_q       <= ex_rd;
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              state   <= S_IDLE;
              st_done <= 1'b1;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (dmem_rvalid) begin
            state    <= S_IDLE;
            wb_valid <= 1'b1;
            wb_data  <= load_c;
            wb_rd    <= rd_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: loads/stores, wait states, back-to-back, reset mid-load.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, ex_we;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done, misalign;

  int n_checks = 0;
  int n_fail   = 0;

  lsu #(.XLEN(32), .RDW(5)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " req"},   {31'h0, dmem_req}, 32'h0);
    check_eq({tag, " we"},    {31'h0, dmem_we}, 32'h0);
    check_eq({tag, " be"},    {28'h0, dmem_be}, 32'h0);
    check_eq({tag, " addr"},  dmem_addr, 32'h0);
    check_eq({tag, " wdata"}, dmem_wdata, 32'h0);
    check_eq({tag, " wbv"},   {31'h0, wb_valid}, 32'h0);
    check_eq({tag, " wbd"},   wb_data, 32'h0);
    check_eq({tag, " wbrd"},  {27'h0, wb_rd}, 32'h0);
    check_eq({tag, " std"},   {31'h0, st_done}, 32'h0);
    check_eq({tag, " mis"},   {31'h0, misalign}, 32'h0);
    check_eq({tag, " rdy"},   {31'h0, ex_ready}, 32'h1);
  endtask

  // zero-wait load: accept at T, gnt at T+1, rvalid at T+2, wb_valid at T+3
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_data);
    ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = f3; ex_addr = addr; ex_rd = rd;
    tick;
    ex_valid = 1'b0;
    check_eq({tag, " req"},  {31'h0, dmem_req}, 32'h1);
    check_eq({tag, " we"},   {31'h0, dmem_we}, 32'h0);
    check_eq({tag, " be"},   {28'h0, dmem_be}, {28'h0, exp_be});
    check_eq({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
    check_eq({tag, " rdy"},  {31'h0, ex_ready}, 32'h0);
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    check_eq({tag, " req_drop"}, {31'h0, dmem_req}, 32'h0);
    check_eq({tag, " wbv_early"}, {31'h0, wb_valid}, 32'h0);
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick;
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    check_eq({tag, " wbv"},  {31'h0, wb_valid}, 32'h1);
    check_eq({tag, " data"}, wb_data, exp_data);
    check_eq({tag, " rd"},   {27'h0, wb_rd}, {27'h0, rd});
    tick;
    check_eq({tag, " wbv_pulse"}, {31'h0, wb_valid}, 32'h0);
    check_eq({tag, " data_hold"}, wb_data, exp_data);
  endtask

  // store with gnt after 'wait_cycles' extra cycles; st_done the cycle after gnt
  task automatic run_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wdata, input int wait_cycles,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    ex_valid = 1'b1; ex_we = 1'b1; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
    tick;
    ex_valid = 1'b0; ex_we = 1'b0; ex_wdata = 32'h0;
    for (int i = 0; i <= wait_cycles; i++) begin
      check_eq({tag, " req"},   {31'h0, dmem_req}, 32'h1);
      check_eq({tag, " we"},    {31'h0, dmem_we}, 32'h1);
      check_eq({tag, " be"},    {28'h0, dmem_be}, {28'h0, exp_be});
      check_eq({tag, " addr"},  dmem_addr, {addr[31:2], 2'b00});
      check_eq({tag, " wdata"}, dmem_wdata, exp_wdata);
      check_eq({tag, " std_early"}, {31'h0, st_done}, 32'h0);
      dmem_gnt = (i == wait_cycles);
      tick;
    end
    dmem_gnt = 1'b0;
    check_eq({tag, " std"}, {31'h0, st_done}, 32'h1);
    check_eq({tag, " req_drop"}, {31'h0, dmem_req}, 32'h0);
    check_eq({tag, " rdy"}, {31'h0, ex_ready}, 32'h1);
    tick;
    check_eq({tag, " std_pulse"}, {31'h0, st_done}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 1'b0; ex_we = 1'b0; ex_funct3 = 3'b000; ex_addr = 32'h0;
    ex_wdata = 32'h0; ex_rd = 5'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    tick; tick;
    check_idle_outputs("reset");
    reset = 1'b0;
    tick;

    run_load("lb",   32'h0000_0103, 3'b000, 5'd5,  32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
    run_load("lhu",  32'h0000_0202, 3'b101, 5'd6,  32'hBEEF_1234, 4'b1100, 32'h0000_BEEF);
    run_load("lh",   32'h0000_0002, 3'b001, 5'd7,  32'h8001_0000, 4'b1100, 32'hFFFF_8001);
    run_load("lbu",  32'h0000_0001, 3'b100, 5'd8,  32'h0000_9A00, 4'b0010, 32'h0000_009A);
    run_load("lh0",  32'h0000_0010, 3'b001, 5'd9,  32'h1234_7FFE, 4'b0011, 32'h0000_7FFE);
    run_load("lw",   32'h0000_0010, 3'b010, 5'd10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    run_load("lill", 32'h0000_0004, 3'b011, 5'd11, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    run_store("sb_wait", 32'h0000_0301, 3'b000, 32'h1234_56A5, 3, 4'b0010, 32'hA5A5_A5A5);
    run_store("sh",      32'h0000_0102, 3'b001, 32'h0000_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
    run_store("sw",      32'h0000_0008, 3'b010, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344);

    // back-to-back LWs: second accept in the cycle of the first wb_valid
    ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h20; ex_rd = 5'd1;
    tick;
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    tick;
    dmem_rvalid = 1'b0;
    check_eq("b2b wbv1",  {31'h0, wb_valid}, 32'h1);
    check_eq("b2b data1", wb_data, 32'h1111_1111);
    check_eq("b2b rdy",   {31'h0, ex_ready}, 32'h1);
    ex_valid = 1'b1; ex_addr = 32'h24; ex_rd = 5'd2;
    tick;
    ex_valid = 1'b0;
    check_eq("b2b req2",  {31'h0, dmem_req}, 32'h1);
    check_eq("b2b addr2", dmem_addr, 32'h24);
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h2222_2222;
    tick;
    dmem_rvalid = 1'b0;
    check_eq("b2b wbv2",  {31'h0, wb_valid}, 32'h1);
    check_eq("b2b data2", wb_data, 32'h2222_2222);
    check_eq("b2b rd2",   {27'h0, wb_rd}, 32'h2);
    tick;

    // reset while waiting in RESP, then a stray rvalid
    ex_valid = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h40; ex_rd = 5'd3;
    tick;
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_resp");
    tick;
    reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick;
    dmem_rvalid = 1'b0;
    check_idle_outputs("stray_rv");
    tick;
    check_eq("stray_rv2 wbv", {31'h0, wb_valid}, 32'h0);

    // misaligned LW
    ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h402; ex_rd = 5'd4;
    tick;
    ex_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    check_eq("mis_lw mis", {31'h0, misalign}, 32'h1);
    check_eq("mis_lw req", {31'h0, dmem_req}, 32'h0);
    check_eq("mis_lw rdy", {31'h0, ex_ready}, 32'h1);
    tick;
    check_eq("mis_lw pulse", {31'h0, misalign}, 32'h0);
    check_eq("mis_lw req2",  {31'h0, dmem_req}, 32'h0);
`else
    check_eq("mis_lw mis",  {31'h0, misalign}, 32'h0);
    check_eq("mis_lw req",  {31'h0, dmem_req}, 32'h1);
    check_eq("mis_lw be",   {28'h0, dmem_be}, 32'hF);
    check_eq("mis_lw addr", dmem_addr, 32'h400);
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    tick;
    dmem_rvalid = 1'b0;
    check_eq("mis_lw wbv",  {31'h0, wb_valid}, 32'h1);
    check_eq("mis_lw data", wb_data, 32'h0BAD_F00D);
`endif
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
